fifo_to_packet: RTL and testbench
=================================

FIFO_TO_PACKET -- requirements
Module: fifo_to_packet

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- pPacketSize, 64, packet length in bytes
- pFifoDataWidth, 2, FIFO word width in bytes
- pTimeout, 256, maximum consecutive empty cycles allowed mid-packet
REQ-002 Derived values: W = pFifoDataWidth*8 bits; N = pPacketSize/pFifoDataWidth words per packet.
REQ-003 pPacketSize SHALL be an integer multiple of pFifoDataWidth, and N SHALL be >= 2.
REQ-004 Ports SHALL be, one per line (name, direction, width, meaning):
- iClk, input, 1, the single clock
- iRst, input, 1, reset; synchronous, active-high
- oRdEn, output, 1, FIFO read strobe
- iRdEmpty, input, 1, FIFO empty flag
- iRdData, input, W, FIFO read data, valid the cycle after oRdEn
- oPacketValid, output, 1, assembled packet available
- oPacketData, output, pPacketSize*8, assembled packet
- iPacketAck, input, 1, consumer has taken the packet
- oErr, output, 1, one-cycle pulse on underrun timeout
REQ-005 All logic SHALL be clocked on the rising edge of iClk.

Function
REQ-006 States SHALL be RD, DRAIN and HOLD.
REQ-007 Counters: rIss (0..N, reads issued), rCap (0..N-1, words captured), rEmptyCnt (0..pTimeout), rRdPend (oRdEn delayed by one cycle).
REQ-008 oRdEn SHALL be combinational: (state==RD) && !iRdEmpty && !iRst; it SHALL never assert when iRdEmpty=1.
REQ-009 When rRdPend=1, iRdData SHALL be written to oPacketData[rCap*W +: W], and rCap SHALL increment. Word 0 occupies the LSBs, which is the inverse of the packet-to-FIFO byte order.
REQ-010 RD: each cycle with oRdEn=1 increments rIss. When rIss reaches N, the state SHALL move to DRAIN.
REQ-011 DRAIN: oRdEn=0. On capture of word N-1, the state SHALL move to HOLD and oPacketValid SHALL be 1 from the next cycle.
REQ-012 Latency: with the FIFO never empty, first oRdEn at cycle T gives oPacketValid=1 at cycle T+N+1, with N contiguous oRdEn cycles.
REQ-013 HOLD: oPacketValid=1 and oPacketData stable, oRdEn=0, until iPacketAck is sampled high. The cycle after the ack, oPacketValid=0, state=RD, and rIss=rCap=0.
REQ-014 iPacketAck SHALL be ignored outside HOLD. An ack in the first cycle of HOLD SHALL be honoured.
REQ-015 Underrun: in RD with 0<rIss<N, rEmptyCnt SHALL count consecutive cycles with iRdEmpty=1 and clear on any oRdEn.
REQ-016 When rEmptyCnt reaches pTimeout, the block SHALL:
- pulse oErr for exactly one cycle
- discard the partial packet (rIss=rCap=0, with pending read data still captured into the discarded slot)
- stay in RD
REQ-017 rEmptyCnt SHALL not run while rIss=0. An idle, empty FIFO is never an error.
REQ-018 oPacketData bits not yet overwritten SHALL keep their prior values. Consumers SHALL use oPacketData only while oPacketValid=1.
REQ-019 Back-to-back packets: after an ack, reading SHALL resume the next cycle if iRdEmpty=0, with one dead cycle between packets.

Reset
REQ-020 iRst=1 at a clock edge SHALL set:
- state=RD
- rIss=rCap=rEmptyCnt=0, rRdPend=0
- oPacketValid=0, oErr=0
- oPacketData=0
REQ-021 oRdEn SHALL be 0 during every cycle in which iRst=1.
REQ-022 Reset in any state, including mid-packet or HOLD, SHALL abandon the packet. FIFO data for a read issued the cycle before reset SHALL be discarded.

Verification
REQ-023 Streaming, N=32, FIFO preloaded with words 0x0100,0x0302,...,0x3F3E -> 32 contiguous oRdEn; oPacketValid at T+33; oPacketData byte i = i.
REQ-024 Hold/ack: iPacketAck held 0 for 50 cycles -> oPacketValid stays 1, oRdEn stays 0, data unchanged; ack pulse -> oPacketValid=0 next cycle.
REQ-025 Gapped FIFO: iRdEmpty toggles every other cycle -> oRdEn only in non-empty cycles; identical packet assembled; oErr never asserts.
REQ-026 Underrun: 5 words, then empty for pTimeout cycles -> single-cycle oErr; next 32 words (0xA5A5) form a packet of all 0xA5.
REQ-027 Reset in DRAIN and in HOLD -> oPacketValid=0 and oPacketData=0 next cycle; the following packet is assembled correctly from word 0.
REQ-028 An ack outside HOLD or an idle empty FIFO for 1000 cycles -> no state change, no oErr.

Source files
------------

// File: rtl/fifo_to_packet.sv
// Assembles fixed-size packets from a FIFO word stream. Word 0 lands in the LSBs.
// A partial packet is dropped with a one-cycle oErr pulse if the FIFO starves mid-packet.
module fifo_to_packet #(
    parameter int pPacketSize    = 64,
    parameter int pFifoDataWidth = 2,
    parameter int pTimeout       = 256
) (
    input  logic                          iClk,
    input  logic                          iRst,
    output logic                          oRdEn,
    input  logic                          iRdEmpty,
    input  logic [pFifoDataWidth*8-1:0]   iRdData,
    output logic                          oPacketValid,
    output logic [pPacketSize*8-1:0]      oPacketData,
    input  logic                          iPacketAck,
    output logic                          oErr
);

    localparam int cWordWidth = pFifoDataWidth * 8;
    localparam int cWords     = pPacketSize / pFifoDataWidth;
    localparam int cIssWidth  = $clog2(cWords + 1);
    localparam int cCapWidth  = $clog2(cWords);
    localparam int cEmptyWidth = $clog2(pTimeout + 1);

    typedef enum logic [1:0] {RD, DRAIN, HOLD} stateT;

    stateT                  state;
    stateT                  stateNext;
    logic [cIssWidth-1:0]   rIss;
    logic [cCapWidth-1:0]   rCap;
    logic [cEmptyWidth-1:0] rEmptyCnt;
    logic                   rRdPend;
    logic                   lastIssue;
    logic                   lastCapture;
    logic                   timeoutHit;

    // Read data trails oRdEn by one cycle, so issue and capture are tracked separately.
    always_comb begin
        stateNext   = state;
        oRdEn       = 1'b0;
        lastIssue   = (rIss == cIssWidth'(cWords - 1));
        lastCapture = rRdPend && (rCap == cCapWidth'(cWords - 1));
        timeoutHit  = (state == RD) && iRdEmpty && (rIss != '0) &&
                      (rEmptyCnt == cEmptyWidth'(pTimeout - 1));
        case (state)
            RD: begin
                oRdEn = !iRdEmpty && !iRst;
                if (oRdEn && lastIssue) stateNext = DRAIN;
            end
            DRAIN: begin
                if (lastCapture) stateNext = HOLD;
            end
            HOLD: begin
                if (iPacketAck) stateNext = RD;
            end
            default: stateNext = RD;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) state <= RD;
        else      state <= stateNext;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rIss         <= '0;
            rCap         <= '0;
            rEmptyCnt    <= '0;
            rRdPend      <= 1'b0;
            oPacketValid <= 1'b0;
            oErr         <= 1'b0;
            oPacketData  <= '0;
        end else begin
            oErr    <= timeoutHit;
            rRdPend <= oRdEn;
            if (rRdPend) begin
                oPacketData[int'(rCap)*cWordWidth +: cWordWidth] <= iRdData;
                rCap <= rCap + 1'b1;
            end
            case (state)
                RD: begin
                    if (oRdEn) begin
                        rIss      <= rIss + 1'b1;
                        rEmptyCnt <= '0;
                    end else if (rIss != '0) begin
                        // A late capture still writes its slot, but the discard wins on rCap.
                        if (timeoutHit) begin
                            rIss      <= '0;
                            rCap      <= '0;
                            rEmptyCnt <= '0;
                        end else begin
                            rEmptyCnt <= rEmptyCnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (lastCapture) begin
                        oPacketValid <= 1'b1;
                        rCap         <= '0;
                    end
                end
                HOLD: begin
                    if (iPacketAck) begin
                        oPacketValid <= 1'b0;
                        rIss         <= '0;
                        rCap         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_to_packet.sv
// Directed bench for fifo_to_packet with a small array-backed FIFO model.
// Inputs change 3ns after the falling edge; outputs are sampled at the same point.
module tb_fifo_to_packet;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         oRdEn;
    logic         iRdEmpty = 1'b1;
    logic [15:0]  iRdData = '0;
    logic         oPacketValid;
    logic [511:0] oPacketData;
    logic         iPacketAck = 1'b0;
    logic         oErr;

    logic [15:0] fifoMem [0:1023];
    int          wrPtr = 0;
    int          rdPtr = 0;
    bit          flushReq = 1'b0;
    bit          gapMode = 1'b0;
    bit          gapPhase = 1'b0;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int rdSeen, rdEmptySeen, errSeen, errCyc, firstRd, lastRd, validRise;
    bit prevValid = 1'b0;

    fifo_to_packet dut (
        .iClk(iClk), .iRst(iRst), .oRdEn(oRdEn), .iRdEmpty(iRdEmpty),
        .iRdData(iRdData), .oPacketValid(oPacketValid), .oPacketData(oPacketData),
        .iPacketAck(iPacketAck), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    // FIFO read side: data appears the cycle after the strobe.
    always @(posedge iClk) begin
        if (flushReq) rdPtr <= wrPtr;
        else if (oRdEn) begin
            iRdData <= fifoMem[rdPtr];
            rdPtr   <= rdPtr + 1;
        end
    end

    always @(negedge iClk) begin
        #1;
        gapPhase = ~gapPhase;
        iRdEmpty = (rdPtr == wrPtr) || (gapMode && gapPhase);
    end

    task automatic tick();
        @(negedge iClk);
        #3;
        cyc++;
        if (oRdEn) begin
            rdSeen++;
            if (firstRd < 0) firstRd = cyc;
            lastRd = cyc;
            if (iRdEmpty) rdEmptySeen++;
        end
        if (oErr) begin
            errSeen++;
            errCyc = cyc;
        end
        if (oPacketValid && !prevValid) validRise = cyc;
        prevValid = oPacketValid;
    endtask

    task automatic clearMon();
        rdSeen = 0; rdEmptySeen = 0; errSeen = 0; errCyc = -1;
        firstRd = -1; lastRd = -1; validRise = -1;
    endtask

    task automatic pushPattern(input logic [7:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            logic [7:0] lo;
            lo = base + 8'(2 * i);
            fifoMem[wrPtr] = {lo + 8'd1, lo};
            wrPtr++;
        end
    endtask

    function automatic logic [511:0] expPacket(input logic [7:0] base);
        logic [511:0] p;
        for (int i = 0; i < 64; i++) p[i*8 +: 8] = base + 8'(i);
        return p;
    endfunction

    task automatic waitValid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (oPacketValid) ok = 1'b1;
        end
    endtask

    task automatic doAck();
        iPacketAck = 1'b1;
        tick();
        iPacketAck = 1'b0;
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        clearMon();
        pushPattern(8'h00, 1);
        repeat (4) tick();
        checks++; if (rdSeen !== 0) $display("[TB] FAIL reset_rden: got %0d strobes expected 0", rdSeen); else passes++;
        checks++; if (oPacketValid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", oPacketValid); else passes++;
        checks++; if (oErr !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", oErr); else passes++;
        checks++; if (oPacketData !== '0) $display("[TB] FAIL reset_data: got %h expected 0", oPacketData); else passes++;
        flushReq = 1'b1;
        tick();
        flushReq = 1'b0;
        tick();
        iRst = 1'b0;
        clearMon();
        repeat (5) tick();
        checks++; if (rdSeen !== 0) $display("[TB] FAIL idle_after_reset: got %0d strobes expected 0", rdSeen); else passes++;
    endtask

    task automatic test_streaming();
        bit ok;
        clearMon();
        pushPattern(8'h00, 32);
        waitValid(100, ok);
        checks++; if (!ok) $display("[TB] FAIL stream_valid: got timeout expected oPacketValid=1"); else passes++;
        checks++; if (rdSeen !== 32) $display("[TB] FAIL stream_rdcount: got %0d expected 32", rdSeen); else passes++;
        checks++; if (lastRd - firstRd !== 31) $display("[TB] FAIL stream_contiguous: got span %0d expected 31", lastRd - firstRd); else passes++;
        checks++; if (validRise - firstRd !== 33) $display("[TB] FAIL stream_latency: got %0d expected 33", validRise - firstRd); else passes++;
        checks++; if (oPacketData !== expPacket(8'h00)) $display("[TB] FAIL stream_data: got %h expected %h", oPacketData, expPacket(8'h00)); else passes++;
    endtask

    task automatic test_hold_ack();
        bit ok;
        int holdBad = 0;
        pushPattern(8'h40, 32);
        clearMon();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!oPacketValid || oRdEn || oPacketData !== expPacket(8'h00)) holdBad++;
        end
        checks++; if (holdBad !== 0) $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0", holdBad); else passes++;
        doAck();
        checks++; if (oPacketValid !== 1'b0) $display("[TB] FAIL ack_valid_drop: got %b expected 0", oPacketValid); else passes++;
        checks++; if (oRdEn !== 1'b1) $display("[TB] FAIL back_to_back_resume: got %b expected 1", oRdEn); else passes++;
        waitValid(100, ok);
        checks++; if (!ok || oPacketData !== expPacket(8'h40)) $display("[TB] FAIL back_to_back_data: got %h expected %h", oPacketData, expPacket(8'h40)); else passes++;
        doAck();
    endtask

    task automatic test_gapped();
        bit ok;
        gapMode = 1'b1;
        clearMon();
        pushPattern(8'h00, 32);
        waitValid(200, ok);
        checks++; if (!ok || oPacketData !== expPacket(8'h00)) $display("[TB] FAIL gap_data: got %h expected %h", oPacketData, expPacket(8'h00)); else passes++;
        checks++; if (rdEmptySeen !== 0) $display("[TB] FAIL gap_rd_when_empty: got %0d expected 0", rdEmptySeen); else passes++;
        checks++; if (rdSeen !== 32) $display("[TB] FAIL gap_rdcount: got %0d expected 32", rdSeen); else passes++;
        checks++; if (errSeen !== 0) $display("[TB] FAIL gap_err: got %0d pulses expected 0", errSeen); else passes++;
        gapMode = 1'b0;
        doAck();
    endtask

    task automatic test_underrun();
        bit ok;
        clearMon();
        pushPattern(8'h10, 5);
        repeat (300) tick();
        checks++; if (errSeen !== 1) $display("[TB] FAIL underrun_err_cycles: got %0d expected 1", errSeen); else passes++;
        checks++; if (errCyc - lastRd !== 257) $display("[TB] FAIL underrun_err_time: got %0d expected 257", errCyc - lastRd); else passes++;
        checks++; if (oPacketValid !== 1'b0) $display("[TB] FAIL underrun_valid: got %b expected 0", oPacketValid); else passes++;
        clearMon();
        for (int i = 0; i < 32; i++) begin
            fifoMem[wrPtr] = 16'hA5A5;
            wrPtr++;
        end
        waitValid(100, ok);
        checks++; if (!ok || oPacketData !== {64{8'hA5}}) $display("[TB] FAIL underrun_next_packet: got %h expected all a5", oPacketData); else passes++;
        checks++; if (errSeen !== 0) $display("[TB] FAIL underrun_extra_err: got %0d expected 0", errSeen); else passes++;
        doAck();
    endtask

    task automatic test_reset_drain();
        bit ok;
        clearMon();
        pushPattern(8'h20, 32);
        for (int i = 0; i < 100 && rdSeen < 32; i++) tick();
        tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        checks++; if (oPacketValid !== 1'b0 || oPacketData !== '0) $display("[TB] FAIL reset_drain: got valid=%b data=%h expected 0/0", oPacketValid, oPacketData); else passes++;
        pushPattern(8'h60, 32);
        waitValid(100, ok);
        checks++; if (!ok || oPacketData !== expPacket(8'h60)) $display("[TB] FAIL after_drain_reset: got %h expected %h", oPacketData, expPacket(8'h60)); else passes++;
        doAck();
    endtask

    task automatic test_reset_hold();
        bit ok;
        pushPattern(8'h30, 32);
        waitValid(100, ok);
        checks++; if (!ok || oPacketData !== expPacket(8'h30)) $display("[TB] FAIL pre_hold_reset: got %h expected %h", oPacketData, expPacket(8'h30)); else passes++;
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        checks++; if (oPacketValid !== 1'b0 || oPacketData !== '0) $display("[TB] FAIL reset_hold: got valid=%b data=%h expected 0/0", oPacketValid, oPacketData); else passes++;
        pushPattern(8'h70, 32);
        waitValid(100, ok);
        checks++; if (!ok || oPacketData !== expPacket(8'h70)) $display("[TB] FAIL after_hold_reset: got %h expected %h", oPacketData, expPacket(8'h70)); else passes++;
        doAck();
    endtask

    task automatic test_idle();
        bit ok;
        clearMon();
        for (int i = 0; i < 1000; i++) begin
            iPacketAck = (i % 7 == 0);
            tick();
        end
        iPacketAck = 1'b0;
        checks++; if (errSeen !== 0) $display("[TB] FAIL idle_err: got %0d expected 0", errSeen); else passes++;
        checks++; if (rdSeen !== 0 || oPacketValid !== 1'b0) $display("[TB] FAIL idle_activity: got rd=%0d valid=%b expected 0/0", rdSeen, oPacketValid); else passes++;
        pushPattern(8'h50, 32);
        waitValid(100, ok);
        checks++; if (!ok || oPacketData !== expPacket(8'h50)) $display("[TB] FAIL idle_then_packet: got %h expected %h", oPacketData, expPacket(8'h50)); else passes++;
        doAck();
    endtask

    initial begin
        clearMon();
        test_reset();
        test_streaming();
        test_hold_ack();
        test_gapped();
        test_underrun();
        test_reset_drain();
        test_reset_hold();
        test_idle();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
